// File: rtl/ariane_pkg.sv
// Shared core definitions: functional-unit opcodes used by the execute stage.
package ariane_pkg;

  typedef enum logic [7:0] {
    ADD  = 8'd0,
    SUB  = 8'd1,
    MUL  = 8'd2,
    MULH = 8'd3,
    DIV  = 8'd4,
    DIVU = 8'd5,
    REM  = 8'd6,
    REMU = 8'd7
  } fu_op;

endpackage

// File: rtl/div_iterative_unit_pkg.sv
// Local definitions for the iterative divider: FSM states and opcode decode helpers.
package div_iterative_unit_pkg;
  import ariane_pkg::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // Opcodes this unit executes; everything else is ignored at the request port.
  function automatic logic is_div_op(input fu_op op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

  function automatic logic is_signed_op(input fu_op op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem_op(input fu_op op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_iterative_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle, DIV/DIVU/REM/REMU,
// single-cycle bypass for divide-by-zero and signed overflow.
module div_iterative_unit
  import ariane_pkg::*;
  import div_iterative_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_BITS = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               div_valid_i,
  output logic               div_ready_o,
  input  fu_op               operation_i,
  input  logic [WIDTH-1:0]   operand_a_i,
  input  logic [WIDTH-1:0]   operand_b_i,
  input  logic [ID_BITS-1:0] trans_id_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               div_valid_o,
  input  logic               out_ready_i,
  output logic [ID_BITS-1:0] div_trans_id_o
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e         state_q, state_d;
  fu_op               op_q, op_d;
  logic [ID_BITS-1:0] id_q, id_d;
  logic [WIDTH-1:0]   quo_q, quo_d;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0]   dvs_q, dvs_d;      // divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic               in_signed, a_neg, b_neg, b_zero, ovf, accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_step, quo_step, quo_fix, rem_fix;

  // Request decode: operand magnitudes and bypass conditions.
  assign in_signed = is_signed_op(operation_i);
  assign a_neg     = in_signed & operand_a_i[WIDTH-1];
  assign b_neg     = in_signed & operand_b_i[WIDTH-1];
  assign abs_a     = a_neg ? WIDTH'(-operand_a_i) : operand_a_i;
  assign abs_b     = b_neg ? WIDTH'(-operand_b_i) : operand_b_i;
  assign b_zero    = (operand_b_i == '0);
  assign ovf       = in_signed && (operand_a_i == MOST_NEG) && (operand_b_i == '1);
  assign accept    = div_valid_i && ready_q && !flush_i && is_div_op(operation_i);

  // One restoring step: shift in next dividend bit, subtract if it fits.
  assign trial    = {rem_q, quo_q[WIDTH-1]};
  assign q_bit    = (trial >= {1'b0, dvs_q});
  assign rem_step = q_bit ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], q_bit};
  assign quo_fix  = q_neg_q ? WIDTH'(-quo_step) : quo_step;
  assign rem_fix  = r_neg_q ? WIDTH'(-rem_step) : rem_step;

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    id_d     = id_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    valid_d  = valid_q;
    ready_d  = ready_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = operation_i;
          id_d    = trans_id_i;
          ready_d = 1'b0;
          if (b_zero || ovf) begin
            if (is_rem_op(operation_i)) begin
              result_d = b_zero ? operand_a_i : '0;
            end else begin
              result_d = b_zero ? '1 : operand_a_i;
            end
            state_d = FINISH;
            valid_d = 1'b1;
          end else begin
            quo_d   = abs_a;
            rem_d   = '0;
            dvs_d   = abs_b;
            cnt_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          result_d = is_rem_op(op_q) ? rem_fix : quo_fix;
          state_d  = FINISH;
          valid_d  = 1'b1;
        end
      end
      FINISH: begin
        if (out_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase

    // Flush wins over everything, including a same-cycle request.
    if (flush_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ready_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= DIVU;
      id_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      id_q     <= id_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign div_ready_o    = ready_q;
  assign div_valid_o    = valid_q;
  assign result_o       = result_q;
  assign div_trans_id_o = id_q;

endmodule
